// File: rtl/inc_dec_counter.sv
// -----------------------------------------------------------------------------
// lau_pkg / inc_dec_prefix / inc_dec_counter
//
// This file holds three pieces:
//   lau_pkg         Shared arithmetic-library types. speed_e selects the
//                   structure of the prefix network.
//   inc_dec_prefix  Parallel-prefix +/-1 unit (IncDec). The result wraps
//                   modulo 2^width.
//   inc_dec_counter Registered up/down counter with a runtime modulus. It
//                   supports wrap or saturate at the limits, parallel load,
//                   a terminal-count flag and a one-cycle boundary pulse.
//
// inc_dec_counter ports:
//   CLK  in   1      clock; all state changes on the rising edge
//   RST  in   1      synchronous active-high reset (Q=0, OVF=0)
//   EN   in   1      count enable, one step per cycle
//   DEC  in   1      direction: 0 = +1, 1 = -1
//   LD   in   1      parallel load of D; takes priority over EN
//   D    in   width  load value (loaded as-is, even when above MAX)
//   MAX  in   width  upper bound of the range [0, MAX]; may change any cycle
//   SAT  in   1      boundary mode: 0 = wrap, 1 = saturate
//   Q    out  width  registered count
//   TC   out  1      terminal count; combinational from Q, DEC and MAX
//   OVF  out  1      registered pulse, high after an enabled boundary step
// -----------------------------------------------------------------------------

package lau_pkg;
  // SMALL: serial ripple of the carry/borrow chain (fewest gates).
  // FAST : Kogge-Stone prefix AND (log2 depth).
  typedef enum logic [0:0] {SMALL = 1'b0, FAST = 1'b1} speed_e;
endpackage

// -----------------------------------------------------------------------------
// inc_dec_prefix: y = dec ? a-1 : a+1  (modulo 2^width)
//   a    in   width  operand
//   dec  in   1      0 = increment, 1 = decrement
//   y    out  width  result
// Bit i toggles when every lower bit is 1 (increment) or every lower bit is
// 0 (decrement). Inverting the operand for decrement turns both cases into
// the same prefix-AND of the propagate vector.
// -----------------------------------------------------------------------------
module inc_dec_prefix #(
  parameter int              width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic [width-1:0] a,
  input  logic             dec,
  output logic [width-1:0] y
);

  // The top bit never propagates into anything, so only width-1 bits are
  // fed into the prefix network.
  logic [width-2:0] prop;
  logic [width-1:0] tgl;

  assign prop   = a[width-2:0] ^ {(width-1){dec}};
  assign tgl[0] = 1'b1;

  if (speed == lau_pkg::FAST) begin : g_fast
    localparam int LVLS = $clog2(width - 1);
    logic [LVLS:0][width-2:0] pre;

    assign pre[0] = prop;
    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
      for (genvar i = 0; i < width - 1; i++) begin : g_bit
        if (i >= (1 << l)) begin : g_cmb
          assign pre[l+1][i] = pre[l][i] & pre[l][i-(1<<l)];
        end else begin : g_pass
          assign pre[l+1][i] = pre[l][i];
        end
      end
    end
    for (genvar i = 1; i < width; i++) begin : g_tgl
      assign tgl[i] = pre[LVLS][i-1];
    end
  end else begin : g_small
    for (genvar i = 1; i < width; i++) begin : g_tgl
      assign tgl[i] = tgl[i-1] & prop[i-1];
    end
  end

  assign y = a ^ tgl;

endmodule

// -----------------------------------------------------------------------------
// inc_dec_counter
// -----------------------------------------------------------------------------
module inc_dec_counter #(
  parameter int              width = 8,
  parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DEC,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic [width-1:0] MAX,
  input  logic             SAT,
  output logic [width-1:0] Q,
  output logic             TC,
  output logic             OVF
);

  logic [width-1:0] step;     // Q +/- 1 from the prefix unit
  logic             at_top;   // Q >= MAX, unsigned
  logic             at_zero;  // Q == 0
  logic [width-1:0] q_nxt;
  logic             ovf_nxt;

  inc_dec_prefix #(
    .width (width),
    .speed (speed)
  ) u_step (
    .a   (Q),
    .dec (DEC),
    .y   (step)
  );

  // The boundary compares run in parallel with the prefix network. Each one
  // only drives a mux select at the end of the path.
  assign at_top  = (Q >= MAX);
  assign at_zero = (Q == '0);

  // TC is high exactly when an enabled step on this edge would raise OVF.
  assign TC = DEC ? at_zero : at_top;

  // Next-state selection for an enabled step. At a boundary the mux replaces
  // the modulo-2^width result, so a raw wrap of the unit never reaches Q.
  // A count above MAX (left by a load or a lowered MAX) steps up into the
  // boundary case, and steps down normally toward the range.
  always_comb begin
    q_nxt   = step;
    ovf_nxt = 1'b0;
    if (TC) begin
      ovf_nxt = 1'b1;
      if (DEC) q_nxt = SAT ? '0  : MAX;
      else     q_nxt = SAT ? MAX : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q   <= '0;
      OVF <= 1'b0;
    end else if (LD) begin
      Q   <= D;
      OVF <= 1'b0;
    end else if (EN) begin
      Q   <= q_nxt;
      OVF <= ovf_nxt;
    end else begin
      OVF <= 1'b0;
    end
  end

endmodule

// File: doc/inc_dec_counter.md
# inc_dec_counter

Registered up/down counter with a runtime modulus, for loop counters, address generators and credit counters in the arithmetic library. Each enabled cycle it steps the count by ±1 and handles the range limits by wrapping or saturating. It also supports parallel load, a terminal-count flag and a one-cycle boundary-event pulse. The ±1 datapath is the library's parallel-prefix incrementer-decrementer (`IncDec`), so its speed/area trade-off comes from `speed`.

## Interface
- `width`, 8: counter word width; legal range ≥ 2.
- `speed`, `lau_pkg::FAST`: performance parameter passed unchanged to the internal `IncDec`.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `EN`  in  1  count enable; one step per cycle while high.
- `DEC`  in  1  direction; 0 = up (+1), 1 = down (−1).
- `LD`  in  1  parallel load; has priority over `EN`.
- `D`  in  `width`  load value.
- `MAX`  in  `width`  upper bound of the count range [0, `MAX`]; may change at any cycle.
- `SAT`  in  1  boundary mode; 0 = wrap, 1 = saturate.
- `Q`  out  `width`  registered count.
- `TC`  out  1  terminal count; combinational from `Q`, `DEC`, `MAX`.
- `OVF`  out  1  registered boundary-event pulse.

## Operation
- Next-state priority, evaluated each rising edge: `RST`, then `LD`, then `EN`, then hold.
- **`RST`=1:** `Q` ← 0 and `OVF` ← 0, regardless of all other inputs.
- **`LD`=1:** `Q` ← `D` exactly, with no clamping even when `D` > `MAX`. `OVF` ← 0. `EN` and `DEC` are ignored.
- **`EN`=1, `DEC`=0 (up):**
  - `Q` < `MAX`: `Q` ← `Q`+1, `OVF` ← 0.
  - `Q` ≥ `MAX`, wrap: `Q` ← 0, `OVF` ← 1.
  - `Q` ≥ `MAX`, saturate: `Q` ← `MAX`, `OVF` ← 1. If `Q` was above `MAX`, this pulls it back into range.
- **`EN`=1, `DEC`=1 (down):**
  - `Q` ≠ 0: `Q` ← `Q`−1, `OVF` ← 0. This also applies when `Q` > `MAX`, so the count walks down toward the range.
  - `Q` = 0, wrap: `Q` ← `MAX`, `OVF` ← 1.
  - `Q` = 0, saturate: `Q` ← 0, `OVF` ← 1.
- **`EN`=0 and `LD`=0:** `Q` holds, `OVF` ← 0. `OVF` is therefore never high for two cycles unless a boundary event occurs on consecutive enabled steps.
- **`TC`:**
  - `TC` = (`Q` ≥ `MAX`) when `DEC`=0.
  - `TC` = (`Q` = 0) when `DEC`=1.
  - `TC` is high in exactly the cycle in which an enabled step would raise `OVF` on the next edge.
- **`MAX` = 0:**
  - Every enabled up step is a boundary event; `Q` goes to 0 in both modes.
  - A down step from 0 also goes to 0 in both modes.
  - `OVF` = 1 after every such step.
- **Arithmetic:** the ±1 result is the `IncDec` output, which is modulo 2^`width`. The boundary checks override it at `Q` ≥ `MAX` (up) and `Q` = 0 (down), so a raw 2^`width` wrap never reaches `Q`. The comparison `Q` ≥ `MAX` is unsigned.
- `SAT` and `MAX` are sampled in the same cycle as the step they affect; there is no internal latching.

## Timing
- Reset values: `Q` = 0, `OVF` = 0. `TC` after reset follows its equation with `Q` = 0 (it is 1 if `DEC`=1 or `MAX`=0).
- Latency: `Q` and `OVF` reflect the inputs sampled at edge n from cycle n+1 onward.
- `TC` has zero latency: it is combinational from `Q` and the current `DEC`/`MAX`, with no path from `EN`, `LD` or `D`.
- `RST` asserted mid-count takes effect at the next edge, overriding `LD`/`EN` in the same cycle. Counting resumes from 0 on the first edge after `RST` is deasserted.
- Throughput: one step per cycle with no bubbles. `DEC` may toggle every cycle.
- Critical path: `Q` → `IncDec` prefix → boundary mux → `Q` register. The mux select comes from a parallel `Q`/`MAX` comparator.

## Test plan
- **Reset:** `width`=8, apply `RST` with `LD`=1, `D`=0x55 → `Q`=0x00, `OVF`=0 on the next cycle.
- **Up wrap:** `MAX`=5, `SAT`=0, `DEC`=0, `EN`=1 for 8 cycles from 0 → `Q` = 1,2,3,4,5,0,1,2. `OVF`=1 only in the cycle `Q` shows 0. `TC`=1 while `Q`=5.
- **Down saturate:** `MAX`=5, `SAT`=1, load 2, then `DEC`=1, `EN`=1 for 4 cycles → `Q` = 1,0,0,0. `OVF` = 0,0,1,1.
- **Out-of-range load:** `MAX`=10, load `D`=200, up step: wrap gives `Q`=0, `OVF`=1; saturate gives `Q`=10, `OVF`=1. From 200 a down step gives 199, `OVF`=0.
- **Priority:** `LD`=1, `EN`=1, `DEC`=1, `D`=7 in one cycle → `Q`=7, `OVF`=0. Next, `EN`=0 for 3 cycles → `Q` holds 7, `OVF`=0.
- **Full range and random:** `width`=8, `MAX`=0xFF, up wrap from 0xFF → 0x00 with `OVF`=1. Then run 10k random cycles of `EN`/`DEC`/`LD`/`SAT`/`MAX`/`RST` against a behavioural model, for both `speed` settings.
